// File: rtl/dmem_if.sv
// MEM-stage bus between the core pipeline and its data memory.
interface dmem_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  funct3;
   logic [31:0] rdata;
   logic        stall;
   logic        misalign_err;

   modport master (
      output mem_req, mem_we, addr, wdata, funct3,
      input  rdata, stall, misalign_err
   );

   modport slave (
      input  mem_req, mem_we, addr, wdata, funct3,
      output rdata, stall, misalign_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the core MEM stage: byte-lane loads/stores with a
// configurable number of wait states reported to the core as a pipeline stall.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 1
) (
   input logic   clk,
   input logic   reset,
   dmem_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             latch_en;
   logic             do_access;
   logic             stall_c;

   logic             lat_we;
   logic [31:0]      lat_addr;
   logic [31:0]      lat_wdata;
   logic [2:0]       lat_f3;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic [31:0]      word;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [31:0]      load_val;
   logic             legal;

   logic [31:0]      rdata_q;
   logic             err_q;
   logic             unused_addr;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state; DONE always returns to IDLE so a held request is not re-served
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_c   = 1'b0;
      latch_en  = 1'b0;
      do_access = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall_c = bus.mem_req;
            if (bus.mem_req) begin
               latch_en = 1'b1;
               cnt_d    = CNT_W'(WAIT_STATES);
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            stall_c = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               do_access = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.stall = stall_c & ~reset;

   // Request capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_f3    <= '0;
      end else if (latch_en) begin
         lat_we    <= bus.mem_we;
         lat_addr  <= bus.addr;
         lat_wdata <= bus.wdata;
         lat_f3    <= bus.funct3;
      end
   end

   // Upper address bits wrap modulo the array size
   assign idx         = lat_addr[IDX_W+1:2];
   assign lane        = lat_addr[1:0];
   assign unused_addr = ^lat_addr[31:IDX_W+2];

   // Size/alignment legality; stores only support the signed encodings
   always_comb begin
      legal = 1'b0;
      case (lat_f3)
         3'b000:  legal = 1'b1;
         3'b001:  legal = ~lane[0];
         3'b010:  legal = (lane == 2'b00);
         3'b100:  legal = ~lat_we;
         3'b101:  legal = ~lat_we & ~lane[0];
         default: legal = 1'b0;
      endcase
   end

   assign word    = mem[idx];
   assign rd_byte = word[{lane, 3'b000} +: 8];
   assign rd_half = lane[1] ? word[31:16] : word[15:0];

   always_comb begin
      load_val = '0;
      case (lat_f3)
         3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
         3'b010:  load_val = word;
         3'b100:  load_val = {24'h0, rd_byte};
         3'b101:  load_val = {16'h0, rd_half};
         default: load_val = '0;
      endcase
   end

   // Array is intentionally not reset; only the BUSY completion edge writes it
   always_ff @(posedge clk) begin
      if (do_access && legal && lat_we) begin
         case (lat_f3[1:0])
            2'b00:   mem[idx][{lane, 3'b000} +: 8]     <= lat_wdata[7:0];
            2'b01:   mem[idx][{lane[1], 4'b0000} +: 16] <= lat_wdata[15:0];
            2'b10:   mem[idx]                          <= lat_wdata;
            default: ;
         endcase
      end
   end

   // Result registers; error is a single-cycle pulse visible in DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (do_access) begin
            err_q   <= ~legal;
            rdata_q <= (legal && !lat_we) ? load_val : 32'h0;
         end
      end
   end

   assign bus.rdata        = rdata_q;
   assign bus.misalign_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with different wait
// states share one driver; a monitor checks each DONE cycle against the queue.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  f3;
   int          sel;

   always #5 clk = ~clk;

   dmem_if b0 ();
   dmem_if b1 ();
   dmem_if b2 ();

   assign b0.mem_req = req && (sel == 0);
   assign b0.mem_we  = we;
   assign b0.addr    = addr;
   assign b0.wdata   = wdata;
   assign b0.funct3  = f3;

   assign b1.mem_req = req && (sel == 1);
   assign b1.mem_we  = we;
   assign b1.addr    = addr;
   assign b1.wdata   = wdata;
   assign b1.funct3  = f3;

   assign b2.mem_req = req && (sel == 2);
   assign b2.mem_we  = we;
   assign b2.addr    = addr;
   assign b2.wdata   = wdata;
   assign b2.funct3  = f3;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u0 (.clk(clk), .reset(rst), .bus(b0.slave));
   dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u1 (.clk(clk), .reset(rst), .bus(b1.slave));
   dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u2 (.clk(clk), .reset(rst), .bus(b2.slave));

   logic        cur_stall;
   logic        cur_err;
   logic [31:0] cur_rdata;

   assign cur_stall = (sel == 0) ? b0.stall : (sel == 1) ? b1.stall : b2.stall;
   assign cur_err   = (sel == 0) ? b0.misalign_err : (sel == 1) ? b1.misalign_err : b2.misalign_err;
   assign cur_rdata = (sel == 0) ? b0.rdata : (sel == 1) ? b1.rdata : b2.rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          stalls;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic int ws_of(input int s);
      return (s == 0) ? 1 : (s == 1) ? 3 : 0;
   endfunction

   // Issue one access; hold keeps mem_req high into the following instruction
   task automatic access(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] fn, input logic [31:0] er, input bit ee, input bit hold);
      exp_t e;
      int   n;
      @(posedge clk);
      #1;
      sel   = s;
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      f3    = fn;
      e.rdata  = er;
      e.err    = ee;
      e.stalls = ws_of(s) + 2;
      sb.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cur_stall && n < 40);
      if (cur_stall) begin
         check("completion_timeout", 32'(n), 32'(e.stalls));
         void'(sb.pop_back());
         req = 1'b0;
         return;
      end
      if (!hold) begin
         @(posedge clk);
         #1 req = 1'b0;
      end
   endtask

   // Monitor: a DONE cycle is the only one with a request present and no stall
   initial begin
      int   run;
      bit   after;
      exp_t e;
      run   = 0;
      after = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            run   = 0;
            after = 1'b0;
         end else begin
            if (after) begin
               check("err_pulse_width", 32'(cur_err), 32'h0);
               after = 1'b0;
            end
            if (req) begin
               if (cur_stall) begin
                  run++;
               end else begin
                  if (sb.size() == 0) begin
                     check("unexpected_done", 32'h1, 32'h0);
                  end else begin
                     e = sb.pop_front();
                     check("rdata", cur_rdata, e.rdata);
                     check("misalign_err", 32'(cur_err), 32'(e.err));
                     check("stall_cycles", 32'(run), 32'(e.stalls));
                  end
                  run   = 0;
                  after = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      req   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      f3    = '0;
      sel   = 0;

      // Reset state, including stall masked while reset is high
      repeat (2) @(negedge clk);
      req = 1'b1;
      #1;
      check("reset_stall", 32'(cur_stall), 32'h0);
      check("reset_rdata0", b0.rdata, 32'h0);
      check("reset_rdata1", b1.rdata, 32'h0);
      check("reset_err0", 32'(b0.misalign_err), 32'h0);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Word write/read, byte store, sign/zero extended loads
      access(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        0, 0);
      access(0, 0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 0, 0);
      access(0, 1, 32'h11, 32'h000000A5, 3'b000, 32'h0,        0, 0);
      access(0, 0, 32'h10, 32'h0,        3'b010, 32'hDEADA5EF, 0, 0);
      access(0, 0, 32'h11, 32'h0,        3'b000, 32'hFFFFFFA5, 0, 0);
      access(0, 0, 32'h11, 32'h0,        3'b100, 32'h000000A5, 0, 0);
      access(0, 0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 0, 0);
      access(0, 0, 32'h12, 32'h0,        3'b101, 32'h0000DEAD, 0, 0);
      access(0, 0, 32'h10, 32'h0,        3'b000, 32'hFFFFFFEF, 0, 0);

      // Illegal accesses: misaligned and unsupported encodings
      access(0, 0, 32'h13, 32'h0,        3'b010, 32'h0,        1, 0);
      access(0, 1, 32'h11, 32'h0000BEEF, 3'b001, 32'h0,        1, 0);
      access(0, 0, 32'h10, 32'h0,        3'b011, 32'h0,        1, 0);
      access(0, 1, 32'h10, 32'h00000000, 3'b100, 32'h0,        1, 0);
      access(0, 0, 32'h10, 32'h0,        3'b010, 32'hDEADA5EF, 0, 0);

      // Halfword store preserves the other half
      access(0, 1, 32'h12, 32'h00001234, 3'b001, 32'h0,        0, 0);
      access(0, 0, 32'h10, 32'h0,        3'b010, 32'h1234A5EF, 0, 0);
      access(0, 0, 32'h10, 32'h0,        3'b001, 32'hFFFFA5EF, 0, 0);

      // Address wrap modulo 256 words
      access(0, 1, 32'h400, 32'h12345678, 3'b010, 32'h0,        0, 0);
      access(0, 0, 32'h0,   32'h0,        3'b010, 32'h12345678, 0, 0);

      // Reset mid-access on the 3-wait-state instance
      access(1, 1, 32'h20, 32'h00000000, 3'b010, 32'h0,        0, 0);
      access(1, 1, 32'h24, 32'h55AA55AA, 3'b010, 32'h0,        0, 0);
      access(1, 0, 32'h24, 32'h0,        3'b010, 32'h55AA55AA, 0, 0);
      @(posedge clk);
      #1;
      sel   = 1;
      req   = 1'b1;
      we    = 1'b1;
      addr  = 32'h20;
      wdata = 32'hFFFFFFFF;
      f3    = 3'b010;
      repeat (3) @(negedge clk);
      check("pre_abort_stall", 32'(cur_stall), 32'h1);
      #1 rst = 1'b1;
      #1;
      check("abort_stall", 32'(cur_stall), 32'h0);
      check("abort_rdata", cur_rdata, 32'h0);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      access(1, 0, 32'h20, 32'h0,        3'b010, 32'h0,        0, 0);

      // Zero wait states with the request held across two instructions
      access(2, 1, 32'h10, 32'hCAFEF00D, 3'b010, 32'h0,        0, 0);
      access(2, 1, 32'h14, 32'h0BADC0DE, 3'b010, 32'h0,        0, 0);
      access(2, 0, 32'h10, 32'h0,        3'b010, 32'hCAFEF00D, 0, 1);
      access(2, 0, 32'h14, 32'h0,        3'b010, 32'h0BADC0DE, 0, 0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RISC-V core: sits on the core's MEM-stage interface and serves its load/store requests (address, store data, funct3 size).
- Returns sign/zero-extended load data and applies byte-lane-masked stores.
- Asserts a stall back to the core for a parameterised number of wait states, so core hazard/stall logic can be exercised against non-ideal memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two.
- WAIT_STATES, 1, extra busy cycles per access; range 0..15.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- mem_req, input, 1, core MEM stage holds a load or store; held stable while stall=1.
- mem_we, input, 1, 1=store, 0=load.
- addr, input, 32, byte address (core ALU_result).
- wdata, input, 32, store data (core WriteData), right-aligned.
- funct3, input, 3, access size/sign from the instruction.
- rdata, output, 32, load result (core ReadData).
- stall, output, 1, freeze core pipeline.
- misalign_err, output, 1, one-cycle pulse when the completed access was illegal.

Behaviour:
- Reset (async):
  - FSM goes to IDLE, counter=0, rdata=0, misalign_err=0; stall=0 while reset is high.
  - The memory array is not reset.
  - Reset mid-access aborts it: no write occurs if reset arrives before the BUSY completion edge.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = mem_req (combinational).
  - On a clock edge with mem_req=1: latch addr, wdata, mem_we, funct3; counter<=WAIT_STATES; go BUSY.
- BUSY:
  - stall=1.
  - If counter!=0: counter<=counter-1.
  - If counter==0: perform the access on this edge and go DONE.
- DONE:
  - stall=0; rdata and misalign_err valid for this cycle; the core consumes the result.
  - Next state is IDLE unconditionally; mem_req seen in DONE is the same instruction and is ignored.
- Latency: stall is high for WAIT_STATES+2 cycles per access, with rdata valid in the cycle stall drops. Back-to-back requests are therefore separated by at least one IDLE cycle.
- Word index = latched addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored (wrap modulo array size).
- Loads (mem_we=0), byte lane from addr[1:0]:
  - 000 LB: sign-extend.
  - 001 LH: sign-extend, halfword from addr[1].
  - 010 LW.
  - 100 LBU: zero-extend.
  - 101 LHU: zero-extend.
- Stores (mem_we=1):
  - 000 SB: wdata[7:0] into lane addr[1:0].
  - 001 SH: wdata[15:0] into the halfword.
  - 010 SW.
  - Untouched bytes are preserved.
  - rdata<=0 on stores.
- Illegal access: halfword with addr[0]=1, word with addr[1:0]!=0, or unsupported funct3 (011, 110, 111, and 1xx for stores).
  - No array write; rdata<=0; misalign_err=1 in DONE only.
- rdata holds its value outside DONE until the next completion or reset.

Test Plan:
1. Reset, then SW addr=0x10 wdata=0xDEADBEEF, WAIT_STATES=1, then LW 0x10 -> each access: stall high 3 cycles, low in DONE; LW returns rdata=0xDEADBEEF; misalign_err=0.
2. After test 1, SB addr=0x11 wdata=0x000000A5, then LW 0x10 -> 0xDEADA5EF. Then LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
3. LW addr=0x13 and SH addr=0x11 -> misalign_err pulses exactly one cycle in DONE; rdata=0; a subsequent LW 0x10 is unchanged at 0xDEADA5EF.
4. Wrap: DEPTH_WORDS=256, SW addr=0x400 wdata=0x12345678, then LW addr=0x0 -> 0x12345678.
5. Reset mid-access: start SW addr=0x20 wdata=0xFFFFFFFF with WAIT_STATES=3 (LW 0x20 preloaded 0 via prior SW 0); assert reset during BUSY -> stall=0 and rdata=0 immediately; after release, LW 0x20 returns 0x00000000.
6. WAIT_STATES=0 and mem_req held continuously across two instructions (LW 0x10 then LW 0x14) -> stall sequence 1,1,0 then IDLE gap, then 1,1,0; correct data for each; the DONE-cycle request is not double-served.
